// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: counts active cycles of a 1-bit spike stream over
// 2^WINDOW_LOG2 clocks and converts the count into a PROB_W-bit rate code.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed window
// RUN   | sampling spike_in_i once per edge until the window wraps
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int PROB_W      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   cont_i,
    input  logic                   spike_in_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [WINDOW_LOG2:0]   count_o,
    output logic [PROB_W-1:0]      rate_o,
    output logic                   saturated_o
);

    localparam int CW    = WINDOW_LOG2 + 1;
    localparam int SHIFT = WINDOW_LOG2 - PROB_W;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((2 ** WINDOW_LOG2) - 1);
    localparam logic [CW-1:0] RATE_MAX    = CW'((2 ** PROB_W) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PROB_W-1:0]   rate_q, rate_d;
    logic                sat_q, sat_d;
    logic                done_q, done_d;
    logic [CW-1:0]       acc_next;
    logic [CW-1:0]       shifted;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            rate_q  <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            rate_q  <= rate_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        rate_d   = rate_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        // The final sample is folded in before the shift so count includes it.
        acc_next = acc_q + {{WINDOW_LOG2{1'b0}}, spike_in_i};
        shifted  = acc_next >> SHIFT;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_SAMPLE) begin
                    count_d = acc_next;
                    done_d  = 1'b1;
                    if (shifted > RATE_MAX) begin
                        rate_d = '1;
                        sat_d  = 1'b1;
                    end else begin
                        rate_d = shifted[PROB_W-1:0];
                        sat_d  = 1'b0;
                    end
                    if (cont_i) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign count_o     = count_q;
    assign rate_o      = rate_q;
    assign saturated_o = sat_q;

endmodule
